// File: rtl/btn_conditioner_if.sv
// Raw button/switch inputs and conditioned
// levels/pulses between board pins and the selector.
interface btn_conditioner_if;
  logic pause_btn;
  logic rst_btn;
  logic sel_sw;
  logic adj_sw;
  logic pause;
  logic pause_pulse;
  logic rst_level;
  logic rst_pulse;
  logic sel;
  logic adj;

  modport master (
    output pause_btn, rst_btn, sel_sw, adj_sw,
    input  pause, pause_pulse, rst_level,
    input  rst_pulse, sel, adj
  );

  modport slave (
    input  pause_btn, rst_btn, sel_sw, adj_sw,
    output pause, pause_pulse, rst_level,
    output rst_pulse, sel, adj
  );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronise and debounce four raw board inputs,
// with press pulses on the pause and reset buttons.
module btn_conditioner #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input logic             clk,
  input logic             reset,
  btn_conditioner_if.slave io
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEB_CYCLES - 1);

  // channel order: 0 pause, 1 rst, 2 sel, 3 adj
  logic [3:0]       raw;
  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       stable;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       prev;
  logic [1:0]       pulse;

  assign raw = {io.adj_sw, io.sel_sw,
                io.rst_btn, io.pause_btn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= LIM) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // prev clears on reset so a held button cannot pulse out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev  <= '0;
      pulse <= '0;
    end else begin
      prev  <= stable[1:0];
      pulse <= stable[1:0] & ~prev;
    end
  end

  assign io.pause       = stable[0];
  assign io.rst_level   = stable[1];
  assign io.sel         = stable[2];
  assign io.adj         = stable[3];
  assign io.pause_pulse = pulse[0];
  assign io.rst_pulse   = pulse[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed checks of btn_conditioner with a
// four-cycle debounce window.
module tb_btn_conditioner;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  btn_conditioner_if io();

  btn_conditioner #(
    .DEB_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pause, pause_pulse, rst_level, rst_pulse, sel, adj}
  function automatic logic [5:0] outs();
    return {io.pause, io.pause_pulse, io.rst_level,
            io.rst_pulse, io.sel, io.adj};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [3:0] v);
    io.adj_sw    = v[3];
    io.sel_sw    = v[2];
    io.rst_btn   = v[1];
    io.pause_btn = v[0];
  endtask

  task automatic settle();
    set_raw(4'b0000);
    repeat (12) tick();
  endtask

  task automatic test_reset();
    logic [5:0] o;
    reset = 1'b0;
    set_raw(4'b1111);
    repeat (3) tick();
    n_chk++;
    o = outs();
    if (o !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_hold got %b want 000000", o);
    end
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      o = outs();
      if (k == 5) begin
        n_chk++;
        if (o !== 6'b000000) begin
          n_fail++;
          $display("FAIL rel_e5 got %b want 000000", o);
        end
      end
      if (k == 6) begin
        n_chk++;
        if (o !== 6'b101011) begin
          n_fail++;
          $display("FAIL rel_e6 got %b want 101011", o);
        end
      end
      if (k == 7) begin
        n_chk++;
        if (o !== 6'b111111) begin
          n_fail++;
          $display("FAIL rel_e7 got %b want 111111", o);
        end
      end
      if (k == 8) begin
        n_chk++;
        if (o !== 6'b101011) begin
          n_fail++;
          $display("FAIL rel_e8 got %b want 101011", o);
        end
      end
    end
    // asynchronous clear between edges
    reset = 1'b0;
    #2;
    o = outs();
    n_chk++;
    if (o !== 6'b000000) begin
      n_fail++;
      $display("FAIL async_rst got %b want 000000", o);
    end
    tick();
    set_raw(4'b0000);
    reset = 1'b1;
    settle();
  endtask

  task automatic test_glitch();
    int nlev;
    int npul;
    nlev = 0;
    npul = 0;
    for (int k = 0; k < 24; k++) begin
      io.pause_btn = (k < 12) ? ~k[0] : 1'b0;
      tick();
      if (io.pause === 1'b1) nlev++;
      if (io.pause_pulse === 1'b1) npul++;
    end
    n_chk++;
    if (nlev != 0) begin
      n_fail++;
      $display("FAIL glitch_level got %0d want 0", nlev);
    end
    n_chk++;
    if (npul != 0) begin
      n_fail++;
      $display("FAIL glitch_pulse got %0d want 0", npul);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int nhigh;
    int npul;
    int p1;
    int p2;
    int rise;
    nhigh = 0;
    npul  = 0;
    p1    = -1;
    p2    = -1;
    rise  = -1;
    for (int k = 0; k < 80; k++) begin
      io.pause_btn = (k < 20) || (k >= 40 && k < 60);
      tick();
      if (io.pause === 1'b1) begin
        nhigh++;
        if (rise < 0) rise = k + 1;
      end
      if (io.pause_pulse === 1'b1) begin
        npul++;
        if (p1 < 0) p1 = k + 1;
        else p2 = k + 1;
      end
    end
    n_chk++;
    if (npul != 2) begin
      n_fail++;
      $display("FAIL b2b_npulse got %0d want 2", npul);
    end
    n_chk++;
    if (p1 != 7 || p2 != 47) begin
      n_fail++;
      $display("FAIL b2b_pulse_edges got %0d,%0d want 7,47",
               p1, p2);
    end
    n_chk++;
    if (nhigh != 40) begin
      n_fail++;
      $display("FAIL b2b_high got %0d want 40", nhigh);
    end
    n_chk++;
    if (rise != 6) begin
      n_fail++;
      $display("FAIL b2b_rise got %0d want 6", rise);
    end
    settle();
  endtask

  task automatic test_switches();
    int rs;
    int ra;
    int npul;
    rs   = -1;
    ra   = -1;
    npul = 0;
    for (int k = 0; k < 30; k++) begin
      io.sel_sw = 1'b1;
      io.adj_sw = (k >= 10);
      tick();
      if (io.sel === 1'b1 && rs < 0) rs = k + 1;
      if (io.adj === 1'b1 && ra < 0) ra = k + 1;
      if (io.pause_pulse === 1'b1) npul++;
      if (io.rst_pulse === 1'b1) npul++;
    end
    n_chk++;
    if (rs != 6) begin
      n_fail++;
      $display("FAIL sel_rise got %0d want 6", rs);
    end
    n_chk++;
    if (ra != 16) begin
      n_fail++;
      $display("FAIL adj_rise got %0d want 16", ra);
    end
    n_chk++;
    if (npul != 0) begin
      n_fail++;
      $display("FAIL sw_pulses got %0d want 0", npul);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    logic [5:0] o;
    int rise;
    int pe;
    int npul;
    rise = -1;
    pe   = -1;
    npul = 0;
    io.rst_btn = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    #2;
    o = outs();
    n_chk++;
    if (o !== 6'b000000) begin
      n_fail++;
      $display("FAIL mid_rst got %b want 000000", o);
    end
    repeat (3) tick();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (io.rst_level === 1'b1 && rise < 0) rise = k;
      if (io.rst_pulse === 1'b1) begin
        npul++;
        if (pe < 0) pe = k;
      end
    end
    n_chk++;
    if (rise != 6) begin
      n_fail++;
      $display("FAIL mid_rise got %0d want 6", rise);
    end
    n_chk++;
    if (npul != 1 || pe != 7) begin
      n_fail++;
      $display("FAIL mid_pulse got n=%0d e=%0d want n=1 e=7",
               npul, pe);
    end
    settle();
  endtask

  task automatic test_simul();
    int ep;
    int er;
    ep = -1;
    er = -1;
    io.pause_btn = 1'b1;
    io.rst_btn   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (io.pause_pulse === 1'b1 && ep < 0) ep = k;
      if (io.rst_pulse === 1'b1 && er < 0) er = k;
    end
    n_chk++;
    if (ep != 7 || er != 7) begin
      n_fail++;
      $display("FAIL simul_pulse got p=%0d r=%0d want 7,7",
               ep, er);
    end
    settle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    set_raw(4'b0000);
    test_reset();
    test_glitch();
    test_back_to_back();
    test_switches();
    test_reset_mid();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Input conditioning stage directly upstream of the stopwatch mode selector. Takes the raw, bouncing board pushbuttons (pause, reset) and slide switches (sel, adj), and synchronises each to clk. Debounces each input with its own counter. Delivers clean levels plus single-cycle press pulses to select_state and the counter datapath.

Parameters:
DEB_CYCLES, 500000, consecutive clk cycles a synchronised input must hold a new value before the debounced output accepts it (5 ms at 100 MHz); legal range 2..2^CNT_W-1
CNT_W, 19, width of each debounce counter; must satisfy 2^CNT_W > DEB_CYCLES

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pause_btn  input  1  raw pause pushbutton, asynchronous, 1 = pressed
rst_btn  input  1  raw stopwatch-reset pushbutton, asynchronous, 1 = pressed
sel_sw  input  1  raw select slide switch, asynchronous
adj_sw  input  1  raw adjust slide switch, asynchronous
pause  output  1  debounced pause button level
pause_pulse  output  1  one-clk pulse on each debounced pause press (0->1)
rst_level  output  1  debounced reset button level
rst_pulse  output  1  one-clk pulse on each debounced reset press (0->1)
sel  output  1  debounced sel switch level
adj  output  1  debounced adj switch level

Behaviour:
- Four identical channels (pause, rst, sel, adj), fully independent; no cross-channel interaction.
- Reset (reset=0, async): both synchroniser flops, stable value, and counter of every channel go to 0. All six outputs read 0 immediately, independent of clk. Deassertion takes effect at the next rising edge; the raw inputs are then resampled from scratch.
- Synchroniser: two flops per channel (s1 <= raw, s2 <= s1). s2 feeds the debouncer. Raw-to-s2 latency is 2 edges.
- Debouncer per channel: register stable, counter cnt[CNT_W-1:0].
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEB_CYCLES-1: stable <= s2, cnt <= 0.
  - Any glitch back to stable before the limit clears cnt. Acceptance needs DEB_CYCLES consecutive differing cycles.
- Latency: after a clean raw transition, the level output changes on rising edge number 2+DEB_CYCLES after the edge that first samples the new raw value.
- Level outputs pause, rst_level, sel, adj are driven directly by the stable registers (registered, no combinational path from inputs).
- Pulse outputs (pause, rst channels only):
  - Registered. prev <= stable each cycle; pulse <= stable & ~prev.
  - Pulse is high for exactly one cycle, one edge after the level rises.
  - No pulse on release (1->0).
  - No pulse out of reset, even if the button is held through reset deassertion. The level rises after the debounce delay and then pulses once; that is intended.
- Counter never wraps: it is bounded by DEB_CYCLES-1 and cleared on acceptance.
- Held button: level stays 1, exactly one pulse. Repeated presses separated by at least DEB_CYCLES released cycles each give one pulse.
- Simultaneous presses on pause and rst: both pulses may assert in the same cycle. Priority is resolved downstream, not here.
- Reset asserted mid-debounce: partial count is discarded, outputs go to 0.

Test Plan:
- DEB_CYCLES=4. Hold reset=0 with all raw inputs at 1 -> all outputs 0. Release reset with inputs held -> levels rise 6 edges after release, pause_pulse and rst_pulse each high exactly one cycle, one edge later.
- DEB_CYCLES=4. Toggle pause_btn 1,0,1,0 each cycle for 12 cycles, then hold 0 -> pause stays 0, pause_pulse never asserts.
- DEB_CYCLES=4. Press pause_btn clean for 20 cycles, release 20, press again 20 -> exactly two pause_pulse cycles. pause level high for two windows of 20 cycles, each delayed 6 edges.
- DEB_CYCLES=4. Set sel_sw=1, then adj_sw=1 ten cycles later -> sel rises 6 edges after sel_sw, adj 6 edges after adj_sw. No pulse outputs fire.
- DEB_CYCLES=4. Press rst_btn; assert reset=0 at count 2, then release with rst_btn still 1 -> rst_level drops to 0 immediately, rises 6 edges after release, one rst_pulse.
- DEB_CYCLES=4. Press pause_btn and rst_btn on the same edge -> pause_pulse and rst_pulse are high on the same cycle.
